// File: rtl/kbd_ascii_latch_pkg.sv
// Shared scan-code constants, parser state type and a character-class helper
// for the keyboard ASCII latch.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;

    // True for A-Z or a-z; only letters react to Caps and Ctrl.
    function automatic logic is_letter(input logic [6:0] c);
        return ((c >= 7'h41) && (c <= 7'h5A)) || ((c >= 7'h61) && (c <= 7'h7A));
    endfunction

endpackage

// File: rtl/kbd_ascii_latch_if.sv
// Keyboard-side bus: scan-code input, CPU consume strobe and the KBD/KBDCR view.
interface kbd_ascii_latch_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       kbd_clr;
    logic [7:0] kbd;
    logic [7:0] kbd_strb;
    logic       kbd_ovf;

    modport master (
        output scan_code, scan_valid, kbd_clr,
        input  kbd, kbd_strb, kbd_ovf
    );

    modport slave (
        input  scan_code, scan_valid, kbd_clr,
        output kbd, kbd_strb, kbd_ovf
    );
endinterface

// File: rtl/kbd_ascii_latch_s2a.sv
// US-layout set-2 scan code to 7-bit ASCII lookup; 0 means unmapped.
module scancode_to_ascii (
    input  logic [7:0] i_scan_code,
    input  logic       i_shift,
    output logic [6:0] o_ascii
);

    logic [13:0] w_pair;  // {unshifted, shifted}

    // Table lookup yields both variants; shift picks one.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_pair = 14'h0;
        case (i_scan_code)
            8'h1C: w_pair = {7'h61, 7'h41};  8'h32: w_pair = {7'h62, 7'h42};
            8'h21: w_pair = {7'h63, 7'h43};  8'h23: w_pair = {7'h64, 7'h44};
            8'h24: w_pair = {7'h65, 7'h45};  8'h2B: w_pair = {7'h66, 7'h46};
            8'h34: w_pair = {7'h67, 7'h47};  8'h33: w_pair = {7'h68, 7'h48};
            8'h43: w_pair = {7'h69, 7'h49};  8'h3B: w_pair = {7'h6A, 7'h4A};
            8'h42: w_pair = {7'h6B, 7'h4B};  8'h4B: w_pair = {7'h6C, 7'h4C};
            8'h3A: w_pair = {7'h6D, 7'h4D};  8'h31: w_pair = {7'h6E, 7'h4E};
            8'h44: w_pair = {7'h6F, 7'h4F};  8'h4D: w_pair = {7'h70, 7'h50};
            8'h15: w_pair = {7'h71, 7'h51};  8'h2D: w_pair = {7'h72, 7'h52};
            8'h1B: w_pair = {7'h73, 7'h53};  8'h2C: w_pair = {7'h74, 7'h54};
            8'h3C: w_pair = {7'h75, 7'h55};  8'h2A: w_pair = {7'h76, 7'h56};
            8'h1D: w_pair = {7'h77, 7'h57};  8'h22: w_pair = {7'h78, 7'h58};
            8'h35: w_pair = {7'h79, 7'h59};  8'h1A: w_pair = {7'h7A, 7'h5A};
            8'h16: w_pair = {7'h31, 7'h21};  8'h1E: w_pair = {7'h32, 7'h40};
            8'h26: w_pair = {7'h33, 7'h23};  8'h25: w_pair = {7'h34, 7'h24};
            8'h2E: w_pair = {7'h35, 7'h25};  8'h36: w_pair = {7'h36, 7'h5E};
            8'h3D: w_pair = {7'h37, 7'h26};  8'h3E: w_pair = {7'h38, 7'h2A};
            8'h46: w_pair = {7'h39, 7'h28};  8'h45: w_pair = {7'h30, 7'h29};
            8'h0E: w_pair = {7'h60, 7'h7E};  8'h4E: w_pair = {7'h2D, 7'h5F};
            8'h55: w_pair = {7'h3D, 7'h2B};  8'h5D: w_pair = {7'h5C, 7'h7C};
            8'h54: w_pair = {7'h5B, 7'h7B};  8'h5B: w_pair = {7'h5D, 7'h7D};
            8'h4C: w_pair = {7'h3B, 7'h3A};  8'h52: w_pair = {7'h27, 7'h22};
            8'h41: w_pair = {7'h2C, 7'h3C};  8'h49: w_pair = {7'h2E, 7'h3E};
            8'h4A: w_pair = {7'h2F, 7'h3F};
            8'h5A: w_pair = {7'h0D, 7'h0D};  8'h66: w_pair = {7'h08, 7'h08};
            8'h76: w_pair = {7'h1B, 7'h1B};  8'h29: w_pair = {7'h20, 7'h20};
            default: w_pair = 14'h0;
        endcase
    end

    assign o_ascii = i_shift ? w_pair[6:0] : w_pair[13:7];

endmodule

// File: rtl/kbd_ascii_latch.sv
// PS/2 set-2 parser, modifier tracking, ASCII translation and a small FIFO
// presenting the Apple-1 KBD / KBDCR registers.
module kbd_ascii_latch
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit UPPER_ONLY = 1'b1
) (
    input  logic               clock_50,
    input  logic               res,
    kbd_ascii_latch_if.slave   bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    kbd_state_t      r_state;
    logic            r_shift, r_ctrl, r_caps;
    logic [6:0]      r_char;
    logic            r_char_vld;
    logic [6:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_last;
    logic            r_ovf;

    logic [6:0]      w_raw, w_char;
    logic            w_full, w_pop, w_push_ok;

    scancode_to_ascii u_s2a (
        .i_scan_code (bus.scan_code),
        .i_shift     (r_shift),
        .o_ascii     (w_raw)
    );

    // Apply Caps and Ctrl to letters, then optionally fold to upper case.
    always_comb begin
        w_char = w_raw;
        if (is_letter(w_raw)) begin
            if (r_caps) w_char[5] = ~w_char[5];
            if (r_ctrl) w_char = w_char & 7'h1F;
        end
        if (UPPER_ONLY && (w_char >= 7'h61) && (w_char <= 7'h7A))
            w_char = w_char - 7'h20;
    end

    // Prefix/modifier parser; a translated make code is registered for the FIFO.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_50) begin
        if (!res) begin
            r_state    <= IDLE;
            r_shift    <= 1'b0;
            r_ctrl     <= 1'b0;
            r_caps     <= 1'b0;
            r_char     <= 7'h0;
            r_char_vld <= 1'b0;
        end else begin
            r_char_vld <= 1'b0;
            if (bus.scan_valid) begin
                unique case (r_state)
                    IDLE: begin
                        case (bus.scan_code)
                            SC_BREAK:             r_state <= BRK;
                            SC_EXT:               r_state <= EXT;
                            SC_LSHIFT, SC_RSHIFT: r_shift <= 1'b1;
                            SC_CTRL:              r_ctrl  <= 1'b1;
                            SC_CAPS:              r_caps  <= ~r_caps;
                            default: begin
                                r_char     <= w_char;
                                r_char_vld <= (w_char != 7'h0);
                            end
                        endcase
                    end
                    BRK: begin
                        if ((bus.scan_code == SC_LSHIFT) || (bus.scan_code == SC_RSHIFT))
                            r_shift <= 1'b0;
                        else if (bus.scan_code == SC_CTRL)
                            r_ctrl <= 1'b0;
                        r_state <= IDLE;
                    end
                    EXT: begin
                        if (bus.scan_code == SC_BREAK)
                            r_state <= EXT_BRK;
                        else begin
                            if (bus.scan_code == SC_CTRL) r_ctrl <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (bus.scan_code == SC_CTRL) r_ctrl <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = bus.kbd_clr && (r_count != '0);
    assign w_push_ok = r_char_vld && (!w_full || w_pop);

    // FIFO storage write port.
    // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are never seen.
    always_ff @(posedge clock_50) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_char;
    end

    // FIFO pointers, occupancy, last-popped byte and sticky overflow.
    always_ff @(posedge clock_50) begin
        if (!res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 8'h80;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= {1'b1, r_mem[r_rd_ptr]};
            end
            if (r_char_vld && w_full && !w_pop) r_ovf <= 1'b1;
            unique case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.kbd      = (r_count != '0) ? {1'b1, r_mem[r_rd_ptr]} : r_last;
    assign bus.kbd_strb = {(r_count != '0), 7'b0};
    assign bus.kbd_ovf  = r_ovf;

endmodule

// File: tb/tb_kbd_ascii_latch.sv
// Directed bench for kbd_ascii_latch with a scoreboard of expected KBD bytes.
module tb_kbd_ascii_latch;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    kbd_ascii_latch_if bus ();

    kbd_ascii_latch #(.DEPTH(4), .UPPER_ONLY(1'b1)) dut (
        .clock_50 (clk),
        .res      (res),
        .bus      (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code, input bit push, input logic [7:0] exp);
        if (push) sb.push_back(exp);
        bus.scan_code  = code;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask

    task automatic pop_pulse();
        bus.kbd_clr = 1'b1;
        @(negedge clk);
        bus.kbd_clr = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic read_check(input string tag);
        logic [7:0] exp;
        check({tag, "_strb"}, bus.kbd_strb, 8'h80);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb: observed=kbd %h expected=no pending char", tag, bus.kbd);
        end else begin
            exp = sb.pop_front();
            check({tag, "_kbd"}, bus.kbd, exp);
        end
        pop_pulse();
    endtask

    // Send a code whose character push edge coincides with a kbd_clr pulse.
    task automatic send_with_clr(input logic [7:0] code, input logic [7:0] exp);
        sb.push_back(exp);
        bus.scan_code  = code;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.kbd_clr    = 1'b1;
        @(negedge clk);
        bus.kbd_clr    = 1'b0;
    endtask

    initial begin
        logic [7:0] head;
        res            = 1'b0;
        bus.scan_code  = 8'h00;
        bus.scan_valid = 1'b0;
        bus.kbd_clr    = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b1;

        check("rst_kbd",  bus.kbd,      8'h80);
        check("rst_strb", bus.kbd_strb, 8'h00);
        check("rst_ovf",  {7'b0, bus.kbd_ovf}, 8'h00);

        // T1: single key, latency and consume
        send(8'h1C, 1'b1, 8'hC1);
        check("t1_strb_n", bus.kbd_strb, 8'h00);
        tick();
        read_check("t1");
        check("t1_post_strb", bus.kbd_strb, 8'h00);
        check("t1_post_kbd",  bus.kbd,      8'hC1);

        // kbd_clr while empty is a no-op
        pop_pulse();
        check("clr_empty_strb", bus.kbd_strb, 8'h00);
        check("clr_empty_kbd",  bus.kbd,      8'hC1);

        // T2: shift, then shift released
        send(8'h12, 1'b0, 8'h00);
        send(8'h16, 1'b1, 8'hA1);
        send(8'hF0, 1'b0, 8'h00);
        send(8'h12, 1'b0, 8'h00);
        send(8'h16, 1'b1, 8'hB1);
        tick();
        read_check("t2_a");
        read_check("t2_b");
        check("t2_empty", bus.kbd_strb, 8'h00);

        // T3: Ctrl+C, then extended ctrl release
        send(8'h14, 1'b0, 8'h00);
        send(8'h21, 1'b1, 8'h83);
        tick();
        read_check("t3_ctrl");
        send(8'hE0, 1'b0, 8'h00);
        send(8'hF0, 1'b0, 8'h00);
        send(8'h14, 1'b0, 8'h00);
        send(8'h21, 1'b1, 8'hC3);
        tick();
        read_check("t3_plain");

        // Caps affects letters only; Enter maps to CR
        send(8'h58, 1'b0, 8'h00);
        send(8'h16, 1'b1, 8'hB1);
        send(8'h1C, 1'b1, 8'hC1);
        send(8'h5A, 1'b1, 8'h8D);
        send(8'h58, 1'b0, 8'h00);
        tick();
        read_check("caps_1");
        read_check("caps_a");
        read_check("caps_cr");

        // T4: overflow on fifth char
        send(8'h1C, 1'b1, 8'hC1);
        send(8'h32, 1'b1, 8'hC2);
        send(8'h21, 1'b1, 8'hC3);
        send(8'h23, 1'b1, 8'hC4);
        tick();
        check("t4_ovf_pre", {7'b0, bus.kbd_ovf}, 8'h00);
        send(8'h24, 1'b0, 8'h00);
        tick();
        check("t4_ovf", {7'b0, bus.kbd_ovf}, 8'h01);
        for (int i = 0; i < 4; i++) read_check($sformatf("t4_rd%0d", i));
        check("t4_empty", bus.kbd_strb, 8'h00);
        check("t4_ovf_sticky", {7'b0, bus.kbd_ovf}, 8'h01);
        do_reset();
        check("t4_ovf_rst", {7'b0, bus.kbd_ovf}, 8'h00);

        // T5: push and pop on the same edge while full
        send(8'h1C, 1'b1, 8'hC1);
        send(8'h32, 1'b1, 8'hC2);
        send(8'h21, 1'b1, 8'hC3);
        send(8'h23, 1'b1, 8'hC4);
        tick();
        head = sb.pop_front();
        check("t5_head", bus.kbd, head);
        send_with_clr(8'h24, 8'hC5);
        check("t5_ovf",  {7'b0, bus.kbd_ovf}, 8'h00);
        for (int i = 0; i < 4; i++) read_check($sformatf("t5_rd%0d", i));
        check("t5_empty", bus.kbd_strb, 8'h00);

        // push and pop on the same edge while empty: pop ignored
        send_with_clr(8'h1C, 8'hC1);
        read_check("t5_empty_pp");
        check("t5_empty_pp_strb", bus.kbd_strb, 8'h00);

        // T6: reset mid-sequence discards break state
        send(8'hF0, 1'b0, 8'h00);
        do_reset();
        check("t6_rst_kbd", bus.kbd, 8'h80);
        send(8'h1C, 1'b1, 8'hC1);
        tick();
        read_check("t6_a");
        send(8'hE0, 1'b0, 8'h00);
        send(8'h75, 1'b0, 8'h00);
        tick();
        check("t6_arrow_strb", bus.kbd_strb, 8'h00);
        check("t6_arrow_kbd",  bus.kbd,      8'hC1);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover: observed=%0d pending expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
